// File: rtl/div_pkg.sv
// Shared types and constants for the restoring integer divider.
// Holds the FSM state encoding and the iteration counter sizing.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit, trial
// subtract the divisor, keep the difference when it does not borrow.
import div_pkg::*;

module div_step #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Trial subtraction; the top bit of diff is the borrow.
    always_comb begin
        shifted = {r_in, q_msb};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        r_out   = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/restoring_integer_divider.sv
// Sequential radix-2 restoring divider, 2W/W -> W quotient and remainder.
// One quotient bit per cycle behind valid/ready handshakes.
import div_pkg::*;

module restoring_integer_divider #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               overflow
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   step_r;
    logic             step_q;
    logic [WIDTH-1:0] hi_word;
    logic [WIDTH-1:0] lo_word;

    assign hi_word = dividend[2*WIDTH-1:WIDTH];
    assign lo_word = dividend[WIDTH-1:0];

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in    (r_q),
        .q_msb   (q_q[WIDTH-1]),
        .divisor (dvs_q),
        .r_out   (step_r),
        .q_bit   (step_q)
    );

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state: accept, iterate WIDTH times, hold result until taken.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    if (hi_word >= divisor) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                        q_d     = '1;
                        r_d     = '0;
                    end else begin
                        state_d = BUSY;
                        ovf_d   = 1'b0;
                        r_d     = {1'b0, hi_word};
                        q_d     = lo_word;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                r_d   = step_r;
                q_d   = {q_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = q_q;
    assign remainder = r_q[WIDTH-1:0];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_restoring_integer_divider.sv
// Directed and randomized checks of the restoring integer divider.
// Expected results come from constants and 64-bit reference arithmetic.
module tb_restoring_integer_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        overflow;

    int total = 0;
    int passes = 0;

    always #5 clk = ~clk;

    restoring_integer_divider #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an operation, wait for acceptance and then for out_valid.
    task automatic run_op(input logic [63:0] dvd, input logic [31:0] dvs,
                          output int lat);
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 200) chk("timeout", 64'(lat), 64'd0);
    endtask

    task automatic consume(input int stall);
        repeat (stall) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [63:0] dvd;
        logic [31:0] dvs;
        logic [31:0] hi;
        logic [63:0] eq;
        logic [63:0] er;
        logic        eo;
        logic [31:0] sq;
        logic [31:0] sr;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(64'd10210000000, 32'd10000000, lat);
        chk("t1_lat", 64'(lat), 64'd32);
        chk("t1_q", 64'(quotient), 64'd1021);
        chk("t1_r", 64'(remainder), 64'd0);
        chk("t1_ovf", 64'(overflow), 64'd0);
        consume(0);

        run_op(64'd4407887546156480, 32'd67445575, lat);
        chk("t2_q", 64'(quotient), 64'd65354733);
        chk("t2_r", 64'(remainder), 64'd5);
        chk("t2_ovf", 64'(overflow), 64'd0);
        consume(2);

        run_op(64'd7, 32'd0, lat);
        chk("dz_lat", 64'(lat), 64'd0);
        chk("dz_ovf", 64'(overflow), 64'd1);
        chk("dz_q", 64'(quotient), 64'hFFFFFFFF);
        chk("dz_r", 64'(remainder), 64'd0);
        consume(0);

        run_op(64'h0000_0005_0000_0000, 32'd5, lat);
        chk("ov5_lat", 64'(lat), 64'd0);
        chk("ov5_ovf", 64'(overflow), 64'd1);
        chk("ov5_q", 64'(quotient), 64'hFFFFFFFF);
        consume(0);

        run_op(64'd1000, 32'd7, lat);
        sq = quotient;
        sr = remainder;
        chk("bp_q", 64'(sq), 64'd142);
        chk("bp_r", 64'(sr), 64'd6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            dividend = 64'd99;
            divisor  = 32'd3;
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_ready", 64'(in_ready), 64'd0);
            chk("bp_hold", {quotient, remainder}, {sq, sr});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_drop", 64'(out_valid), 64'd0);
        chk("bp_idle", 64'(in_ready), 64'd1);
        run_op(64'd55, 32'd4, lat);
        chk("bp2_lat", 64'(lat), 64'd32);
        chk("bp2_q", 64'(quotient), 64'd13);
        chk("bp2_r", 64'(remainder), 64'd3);
        consume(0);

        @(negedge clk);
        in_valid = 1'b1;
        dividend = 64'd123456789;
        divisor  = 32'd1000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_ready", 64'(in_ready), 64'd1);
        chk("mr_q", 64'(quotient), 64'd0);
        chk("mr_r", 64'(remainder), 64'd0);
        chk("mr_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(64'd100, 32'd7, lat);
        chk("mr2_q", 64'(quotient), 64'd14);
        chk("mr2_r", 64'(remainder), 64'd2);
        consume(0);

        for (int n = 0; n < 1000; n++) begin
            dvs = $urandom;
            if (n % 97 == 0) dvs = 32'd0;
            if (n % 50 == 1) dvs = 32'd1;
            if (dvs == 32'd0) hi = $urandom;
            else if (n % 10 == 3) hi = dvs - 32'd1;
            else if (dvs == 32'd1) hi = 32'd0;
            else hi = $urandom % dvs;
            if (n % 53 == 7) hi = dvs;
            dvd = {hi, 32'($urandom)};
            eo = (hi >= dvs);
            if (eo) begin
                eq = 64'hFFFFFFFF;
                er = 64'd0;
            end else begin
                eq = dvd / {32'd0, dvs};
                er = dvd % {32'd0, dvs};
            end
            run_op(dvd, dvs, lat);
            chk("rnd_ovf", 64'(overflow), 64'(eo));
            chk("rnd_q", 64'(quotient), eq);
            chk("rnd_r", 64'(remainder), er);
            if (!eo) begin
                chk("rnd_inv",
                    64'(quotient) * {32'd0, dvs} + 64'(remainder), dvd);
            end
            consume(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
